// File: rtl/ram_port_arbiter.sv
// Two-client arbiter in front of a dual-port RAM: independent round-robin on the
// write and read ports, read-data return routing, and same-address bypass.
module ram_port_arbiter #(
  parameter int DEPTH  = 16,
  parameter int DWIDTH = 8,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [AWIDTH-1:0] c0_addr,
  input  logic [DWIDTH-1:0] c0_wdata,
  output logic              c0_gnt,
  output logic              c0_rvalid,
  output logic [DWIDTH-1:0] c0_rdata,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [AWIDTH-1:0] c1_addr,
  input  logic [DWIDTH-1:0] c1_wdata,
  output logic              c1_gnt,
  output logic              c1_rvalid,
  output logic [DWIDTH-1:0] c1_rdata,
  output logic              wr_enbl,
  output logic [AWIDTH-1:0] wr_addr,
  output logic [DWIDTH-1:0] wr_data,
  output logic              rd_enbl,
  output logic [AWIDTH-1:0] rd_addr,
  input  logic [DWIDTH-1:0] rd_data
);

  // Handshake: a client transfers at a posedge where req & gnt; it holds
  // we/addr/wdata stable while req is high and gnt is low.

  logic              wr_pri, rd_pri;
  logic [1:0]        wr_cand, rd_cand;
  logic              wr_win, rd_win;
  logic              tag0_v, tag0_id;
  logic              tag1_v, tag1_id, byp1;
  logic [DWIDTH-1:0] byp_data;
  logic [DWIDTH-1:0] ret_data;

  // Candidates are masked during reset so every output reads 0 then.
  always_comb begin
    wr_cand = {c1_req & c1_we, c0_req & c0_we} & {2{~rst}};
    rd_cand = {c1_req & ~c1_we, c0_req & ~c0_we} & {2{~rst}};
    wr_win  = (wr_cand == 2'b11) ? wr_pri : wr_cand[1];
    rd_win  = (rd_cand == 2'b11) ? rd_pri : rd_cand[1];
    c0_gnt  = (wr_cand[0] & ~wr_win) | (rd_cand[0] & ~rd_win);
    c1_gnt  = (wr_cand[1] & wr_win) | (rd_cand[1] & rd_win);
  end

  // Priority moves to the loser only after a contested grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pri <= 1'b0;
      rd_pri <= 1'b0;
    end else begin
      if (wr_cand == 2'b11) wr_pri <= ~wr_win;
      if (rd_cand == 2'b11) rd_pri <= ~rd_win;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_enbl <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rd_enbl <= 1'b0;
      rd_addr <= '0;
    end else begin
      wr_enbl <= |wr_cand;
      rd_enbl <= |rd_cand;
      if (|wr_cand) begin
        wr_addr <= wr_win ? c1_addr : c0_addr;
        wr_data <= wr_win ? c1_wdata : c0_wdata;
      end
      if (|rd_cand) rd_addr <= rd_win ? c1_addr : c0_addr;
    end
  end

  // Stage 0 lines up with rd_enbl, stage 1 with rd_data; the bypass decision
  // is taken from the registered commands as the tag enters stage 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag0_v   <= 1'b0;
      tag0_id  <= 1'b0;
      tag1_v   <= 1'b0;
      tag1_id  <= 1'b0;
      byp1     <= 1'b0;
      byp_data <= '0;
    end else begin
      tag0_v   <= |rd_cand;
      tag0_id  <= rd_win;
      tag1_v   <= tag0_v;
      tag1_id  <= tag0_id;
      byp1     <= rd_enbl & wr_enbl & (rd_addr == wr_addr);
      byp_data <= wr_data;
    end
  end

  assign ret_data = byp1 ? byp_data : rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c0_rvalid <= 1'b0;
      c1_rvalid <= 1'b0;
      c0_rdata  <= '0;
      c1_rdata  <= '0;
    end else begin
      c0_rvalid <= tag1_v & ~tag1_id;
      c1_rvalid <= tag1_v & tag1_id;
      if (tag1_v & ~tag1_id) c0_rdata <= ret_data;
      if (tag1_v & tag1_id)  c1_rdata <= ret_data;
    end
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-client arbiter that shares the dual-port RAM between requesters. Write requests are arbitrated onto the RAM write port and read requests onto the read port, each with its own round-robin priority. Read data is routed back to the issuing client with a one-cycle valid pulse. Same-cycle read/write collisions on one address are resolved by bypass. The block sits between client logic and the RAM and drives every RAM input.

## Interface
Parameters:
- DEPTH, 16, RAM word count
- DWIDTH, 8, data width in bits
- AWIDTH, $clog2(DEPTH), address width

Ports (N = 0, 1; c1_* mirrors c0_*):
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  reset, asynchronous, active-high
- cN_req  input  1  client N request; held with we/addr/wdata until granted
- cN_we  input  1  1 = write, 0 = read
- cN_addr  input  AWIDTH  request address
- cN_wdata  input  DWIDTH  write data
- cN_gnt  output  1  combinational grant; a handshake occurs at a posedge with req&gnt
- cN_rvalid  output  1  registered one-cycle pulse, read data valid
- cN_rdata  output  DWIDTH  registered read data, held until next rvalid
- wr_enbl, wr_addr, wr_data  output  1/AWIDTH/DWIDTH  RAM write command, registered
- rd_enbl, rd_addr  output  1/AWIDTH  RAM read command, registered
- rd_data  input  DWIDTH  RAM read data, valid in the cycle after the RAM samples rd_enbl

## Operation
- Write candidates are clients with req&we. Read candidates are clients with req&!we. The two ports arbitrate independently in the same cycle.
- One candidate on a port: it is granted.
- Two candidates on a port: the port's priority bit (wr_pri / rd_pri) selects the winner. After the grant, the bit toggles to the loser.
  - An uncontested grant leaves the bit unchanged.
- Each client receives at most one grant per cycle. A non-requesting client has gnt = 0.
- The controller never stalls. Every cycle with a candidate produces a grant on that port.
- Handshake edge E: RAM command registers load.
  - Write: wr_enbl=1, wr_addr, wr_data from the winner.
  - Read: rd_enbl=1, rd_addr from the winner.
  - A port with no grant loads enbl=0 and holds its addr/data.
- Read tag pipeline is 2 stages of {valid, client id}, shifted every cycle.
  - Stage 0 loads at E and aligns with rd_enbl.
  - Stage 1 aligns with rd_data.
  - At stage-1 exit, cN_rdata captures the data and cN_rvalid pulses for the tagged client.
- Collision bypass applies when the registered commands have rd_enbl & wr_enbl & rd_addr == wr_addr.
  - The bypass flag and wr_data are captured alongside the tag.
  - The returned data is that write data, not rd_data (write-before-read semantics).
- A write at edge E followed by a read of the same address at E+1 needs no bypass, because the RAM is already updated.

## Timing
- Grant is combinational from req/we and the priority bits, with zero latency.
- The write commits into the RAM at E+1.
- Read latency: handshake at E gives cN_rvalid high for exactly the cycle after edge E+2. Back-to-back reads give back-to-back rvalids in order.
- Reset (async assert, any time):
  - All outputs = 0, including cN_rdata, wr_addr, wr_data and rd_addr.
  - Priority bits = 0, so client 0 wins the first contest on each port.
  - Tag pipeline cleared; in-flight reads are dropped and produce no rvalid after release.
- The first handshake is possible at the first posedge with rst low.
- If a client changes we/addr/wdata while req=1 and gnt=0, the behaviour is undefined. The bench checks that clients keep the request stable.

## Test plan
- Reset then single write: c0 writes addr 3 = 0xA5 → c0_gnt=1 same cycle; wr_enbl=1, wr_addr=3, wr_data=0xA5 for one cycle after E. Then c0 reads addr 3 → c0_rvalid pulse 2 cycles later with c0_rdata=0xA5.
- Write contention: both clients hold write requests for 4 cycles → grants alternate c0, c1, c0, c1; wr_enbl stays high 4 consecutive cycles with the matching addresses.
- Read contention and routing: memory preloaded with addr N = N+0x10; c0 reads 2 and c1 reads 5 continuously.
  - Reads alternate between the two clients.
  - c0_rvalid only ever carries 0x12 and c1_rvalid only ever carries 0x15, each 2 cycles after its grant.
- Collision bypass: addr 7 = 0x11; at the same edge c0 writes 7 = 0x99 and c1 reads 7 → c1_rdata=0x99 with c1_rvalid. A later read of 7 also returns 0x99.
- Mixed ports: c0 writes while c1 reads in the same cycles → both granted every cycle, no priority toggling, both RAM commands issued together.
- Reset mid-read: c1 read handshake at E, rst asserted between E and E+1 → all outputs 0 immediately; no c1_rvalid after release; the next contest is won by c0.
